// File: rtl/mul_dispatch_pkg.sv
// Shared types for the multiplier pair dispatcher: the FSM state encoding,
// the 32-bit IEEE754 single word type and the operand pair record.
package mul_dispatch_pkg;

    // Raw IEEE754 single-precision word; the dispatcher never interprets it.
    typedef logic [31:0] float_word_t;

    localparam float_word_t FLOAT_ZERO = 32'h0000_0000;

    // Dispatcher FSM states, in the order a normal transaction visits them.
    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_HAVE_A    = 4'd1,
        ST_REQ       = 4'd2,
        ST_OP_A      = 4'd3,
        ST_OP_B      = 4'd4,
        ST_WAIT_DONE = 4'd5,
        ST_CAP_B     = 4'd6,
        ST_DRAIN_A   = 4'd7,
        ST_DRAIN_B   = 4'd8
    } state_t;

    // One operand pair as handed to the multiplier in a single cycle.
    typedef struct packed {
        float_word_t op1;
        float_word_t op2;
    } pair_t;

    // States in which the upstream side may hand over a new pair.
    function automatic logic accepts_input(input state_t s);
        return (s == ST_IDLE) || (s == ST_HAVE_A);
    endfunction

endpackage

// File: rtl/edge_detect_rise.sv
// Rising-edge detector: flags the cycle where d is high and was low on the
// previous cycle. A level that is already high never produces a flag.
module edge_detect_rise (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q;

    // Remember the previous cycle's level of d.
    always_ff @(posedge clk) begin
        if (rst) begin
            d_q <= 1'b0;
        end else begin
            d_q <= d;
        end
    end

    assign rise = d & ~d_q;

endmodule

// File: rtl/mul_pair_dispatcher.sv
// Multiplier pair dispatcher: collects two operand pairs (A then B), feeds
// them to a shared multiplier after a one-cycle start pulse, captures both
// products (A on the mul_done rising edge, B one cycle later) and drains
// them downstream in input order. A lone pair can be pushed through with
// flush; its partner slot is then filled with zeros and its result dropped.
//
// Optional feature: define MUL_DISPATCH_TIMEOUT_EN to bound the wait for
// mul_done to TIMEOUT_CYCLES cycles and raise the sticky err_timeout flag.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; a producer holding valid keeps its data stable until then
// (in_valid/in_ready upstream, out_valid/out_ready downstream).
module mul_pair_dispatcher
    import mul_dispatch_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_op1,
    input  logic [31:0] in_op2,
    input  logic        flush,
    output logic        mul_ready,
    output logic [31:0] mul_op1,
    output logic [31:0] mul_op2,
    input  logic [31:0] mul_res,
    input  logic        mul_done,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_res,
    output logic        busy,
    output logic        err_timeout
);

    state_t      state;
    state_t      state_nx;
    pair_t       pair_a;
    pair_t       pair_b;
    logic        discard_b;
    float_word_t res_a;
    float_word_t res_b;
    logic        xfer;
    logic        done_rise;
    logic        timeout_hit;

    assign xfer = in_valid & in_ready;

    // mul_done qualifier: only a fresh rising edge counts as completion.
    edge_detect_rise u_done_edge (
        .clk  (clk),
        .rst  (rst),
        .d    (mul_done),
        .rise (done_rise)
    );

`ifdef MUL_DISPATCH_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    // Count cycles spent in WAIT_DONE; the count restarts on every entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if ((state == ST_WAIT_DONE) && !done_rise) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // The last allowed WAIT_DONE cycle without a rising edge gives up.
    // A rising edge in that same cycle still wins.
    assign timeout_hit = (state == ST_WAIT_DONE) && !done_rise &&
                         (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (timeout_hit) begin
            err_q <= 1'b1;
        end
    end

    assign err_timeout = err_q;
`else
    // Without the timeout the parameter only documents the interface.
    logic timeout_cfg_unused;
    assign timeout_cfg_unused = (TIMEOUT_CYCLES != 0);

    assign timeout_hit = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE: begin
                if (xfer) state_nx = ST_HAVE_A;
            end
            ST_HAVE_A: begin
                // A transfer and a flush in the same cycle both lead to REQ;
                // the datapath lets the transfer decide what pair B holds.
                if (xfer || flush) state_nx = ST_REQ;
            end
            ST_REQ:  state_nx = ST_OP_A;
            ST_OP_A: state_nx = ST_OP_B;
            ST_OP_B: state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (done_rise) begin
                    state_nx = ST_CAP_B;
                end else if (timeout_hit) begin
                    state_nx = ST_IDLE;
                end
            end
            ST_CAP_B: state_nx = ST_DRAIN_A;
            ST_DRAIN_A: begin
                if (out_ready) begin
                    state_nx = discard_b ? ST_IDLE : ST_DRAIN_B;
                end
            end
            ST_DRAIN_B: begin
                if (out_ready) state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // Operand and result buffers; everything is dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pair_a    <= '0;
            pair_b    <= '0;
            discard_b <= 1'b0;
            res_a     <= FLOAT_ZERO;
            res_b     <= FLOAT_ZERO;
        end else begin
            if ((state == ST_IDLE) && xfer) begin
                pair_a <= '{op1: in_op1, op2: in_op2};
            end
            if (state == ST_HAVE_A) begin
                if (xfer) begin
                    pair_b    <= '{op1: in_op1, op2: in_op2};
                    discard_b <= 1'b0;
                end else if (flush) begin
                    pair_b    <= '{op1: FLOAT_ZERO, op2: FLOAT_ZERO};
                    discard_b <= 1'b1;
                end
            end
            if ((state == ST_WAIT_DONE) && done_rise) begin
                res_a <= mul_res;
            end
            if (state == ST_CAP_B) begin
                res_b <= mul_res;
            end
            if (timeout_hit) begin
                res_a <= FLOAT_ZERO;
                res_b <= FLOAT_ZERO;
            end
        end
    end

    // Outputs decoded from the state; everything reads as idle during reset.
    always_comb begin
        in_ready  = 1'b0;
        mul_ready = 1'b0;
        mul_op1   = FLOAT_ZERO;
        mul_op2   = FLOAT_ZERO;
        out_valid = 1'b0;
        out_res   = FLOAT_ZERO;
        busy      = 1'b0;
        if (!rst) begin
            in_ready = accepts_input(state);
            busy     = (state != ST_IDLE);
            case (state)
                ST_REQ: mul_ready = 1'b1;
                ST_OP_A: begin
                    mul_op1 = pair_a.op1;
                    mul_op2 = pair_a.op2;
                end
                ST_OP_B: begin
                    mul_op1 = pair_b.op1;
                    mul_op2 = pair_b.op2;
                end
                ST_DRAIN_A: begin
                    out_valid = 1'b1;
                    out_res   = res_a;
                end
                ST_DRAIN_B: begin
                    out_valid = 1'b1;
                    out_res   = res_b;
                end
                default: ;
            endcase
        end
    end

endmodule
